// File: rtl/lieat_ifu_bpu_bht.sv
// Branch history table: 2-bit saturating counters indexed by PC, with a one-cycle
// registered lookup pipe (stall hold, flush kill), same-cycle update bypass and perf counters.
module lieat_ifu_bpu_bht #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             ifu_req_valid,
    input  logic [XLEN-1:0]  ifu_req_pc,
    input  logic [XLEN-1:0]  ifu_req_imm,
    input  logic             ifu_req_bxx,
    input  logic             ifu_stall,
    input  logic             ifu_flush,

    output logic             ifu_rsp_valid,
    output logic             ifu_rsp_taken,
    output logic [XLEN-1:0]  ifu_rsp_pc,
    output logic [IDX_W-1:0] ifu_rsp_index,

    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_res,

    output logic [CNT_W-1:0] perf_upd_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } cnt_e;

    cnt_e              cnt_q [DEPTH];
    cnt_e              cnt_d [DEPTH];
    cnt_e              cnt_upd;

    logic [IDX_W-1:0]  lk_idx;
    cnt_e              lk_cnt;
    logic              lk_taken;
    logic [XLEN-1:0]   lk_npc;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_taken_q, rsp_taken_d;
    logic [XLEN-1:0]   rsp_pc_q,    rsp_pc_d;
    logic [IDX_W-1:0]  rsp_index_q, rsp_index_d;

    logic [CNT_W-1:0]  upd_cnt_q,   upd_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // Saturating step of the counter being resolved this cycle.
    always_comb begin
        cnt_upd = cnt_q[upd_index];
        if (upd_res) begin
            if (cnt_q[upd_index] != CNT_STRONG_T) begin
                cnt_upd = cnt_e'(cnt_q[upd_index] + 2'd1);
            end
        end else begin
            if (cnt_q[upd_index] != CNT_STRONG_NT) begin
                cnt_upd = cnt_e'(cnt_q[upd_index] - 2'd1);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (upd_en) begin
            cnt_d[upd_index] = cnt_upd;
        end
    end

    // NOTE: the table is a register array, not a RAM, because every entry must
    // return to weakly-not-taken on reset; the loop below resets all entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_WEAK_NT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Lookup sees the post-update value when it collides with this cycle's update.
    always_comb begin
        lk_idx   = ifu_req_pc[IDX_W+1:2];
        lk_cnt   = (upd_en && (upd_index == lk_idx)) ? cnt_upd : cnt_q[lk_idx];
        lk_taken = ifu_req_bxx & lk_cnt[1];
        lk_npc   = ifu_req_pc + (lk_taken ? ifu_req_imm : XLEN'(4));
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_taken_d = rsp_taken_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_index_d = rsp_index_q;
        if (ifu_flush) begin
            rsp_valid_d = 1'b0;
        end else if (!ifu_stall) begin
            rsp_valid_d = ifu_req_valid;
            if (ifu_req_valid) begin
                rsp_taken_d = lk_taken;
                rsp_pc_d    = lk_npc;
                rsp_index_d = lk_idx;
            end
        end
    end

    always_comb begin
        upd_cnt_d   = upd_cnt_q   + (upd_en    ? CNT_W'(1) : CNT_W'(0));
        flush_cnt_d = flush_cnt_q + (ifu_flush ? CNT_W'(1) : CNT_W'(0));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_taken_q <= 1'b0;
            rsp_pc_q    <= '0;
            rsp_index_q <= '0;
            upd_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_taken_q <= rsp_taken_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_index_q <= rsp_index_d;
            upd_cnt_q   <= upd_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ifu_rsp_valid  = rsp_valid_q;
    assign ifu_rsp_taken  = rsp_taken_q;
    assign ifu_rsp_pc     = rsp_pc_q;
    assign ifu_rsp_index  = rsp_index_q;
    assign perf_upd_cnt   = upd_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;

endmodule
